// File: rtl/apb_slave_ni.sv
// apb_slave_ni: APB completer that packs each transfer into a NoC request flit and completes it from the matching response flit
module apb_slave_ni #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic                           req_fifo_full,
  output logic                           req_fifo_wr_en,
  output logic [ADDR_WIDTH+DATA_WIDTH:0] req_fifo_wdata,
  input  logic                           resp_fifo_empty,
  output logic                           resp_fifo_rd_en,
  input  logic [DATA_WIDTH:0]            resp_fifo_rdata
);
  localparam int REQ_FLIT_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CW         = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, DRAIN, PUSH_REQ, WAIT_RESP, SAMPLE_RESP, DONE} state_t;
  state_t state, state_n;
  logic [REQ_FLIT_W-1:0] flit;
  logic [CW-1:0] cnt;
  logic stale, deferred, timeout, accept;
  assign timeout        = cnt == CW'(TIMEOUT_CYCLES - 1);
  // a setup held off by a stale response is picked up later in its access phase
  assign accept         = psel && !stale && (!penable || deferred);
  assign pready         = state == DONE;
  assign req_fifo_wdata = flit;
  always_comb begin
    state_n         = state;
    req_fifo_wr_en  = 1'b0;
    resp_fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (stale && !resp_fifo_empty) begin
          resp_fifo_rd_en = 1'b1;
          state_n         = DRAIN;
        end else if (accept) state_n = PUSH_REQ;
      end
      DRAIN: state_n = IDLE;
      PUSH_REQ: begin
        req_fifo_wr_en = !req_fifo_full;
        state_n        = req_fifo_full ? PUSH_REQ : WAIT_RESP;
      end
      WAIT_RESP: begin
        resp_fifo_rd_en = !resp_fifo_empty;
        state_n         = !resp_fifo_empty ? SAMPLE_RESP : timeout ? DONE : WAIT_RESP;
      end
      SAMPLE_RESP: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      flit     <= '0;
      cnt      <= '0;
      stale    <= 1'b0;
      deferred <= 1'b0;
      prdata   <= '0;
      pslverr  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= state == WAIT_RESP ? cnt + CW'(1) : '0;
      if (state == IDLE && state_n == PUSH_REQ) flit <= {pwrite, paddr, pwdata};
      if (state == IDLE)
        deferred <= state_n == PUSH_REQ ? 1'b0 : deferred | (stale & psel & ~penable);
      if (state == DRAIN) stale <= 1'b0;
      if (state == WAIT_RESP && resp_fifo_empty && timeout) begin
        stale   <= 1'b1;
        prdata  <= '0;
        pslverr <= 1'b1;
      end
      if (state == SAMPLE_RESP) begin
        prdata  <= flit[REQ_FLIT_W-1] ? '0 : resp_fifo_rdata[DATA_WIDTH-1:0];
        pslverr <= resp_fifo_rdata[DATA_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_apb_slave_ni.sv
// tb_apb_slave_ni: table-driven APB transfers against FIFO models with a scoreboard of flits and completions
module tb_apb_slave_ni;
  logic clk = 0, rst = 1, psel = 0, penable = 0, pwrite = 0;
  logic [31:0] paddr = 0, pwdata = 0, prdata;
  logic pready, pslverr, req_fifo_wr_en, resp_fifo_rd_en;
  logic req_fifo_full = 0, resp_fifo_empty = 1;
  logic [64:0] req_fifo_wdata;
  logic [32:0] resp_fifo_rdata = 0;
  apb_slave_ni #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .req_fifo_full(req_fifo_full), .req_fifo_wr_en(req_fifo_wr_en), .req_fifo_wdata(req_fifo_wdata),
    .resp_fifo_empty(resp_fifo_empty), .resp_fifo_rd_en(resp_fifo_rd_en), .resp_fifo_rdata(resp_fifo_rdata)
  );
  always #5 clk = ~clk;
  typedef struct { logic w; logic [31:0] a, d; int f, dly; logic [32:0] resp; logic [31:0] xd; logic xe; int lat; } vec_t;
  typedef struct { int dly; logic [32:0] resp; } plan_t;
  typedef struct { logic [31:0] xd; logic xe; int lat; int t0; } done_t;
  typedef struct { int at; logic [32:0] resp; } pend_t;
  logic [64:0] fq[$];
  plan_t pq[$];
  done_t dq[$];
  pend_t pnd[$];
  logic [32:0] rq[$];
  vec_t tbl[9];
  int cyc_n = 0, pass_n = 0, tot_n = 0, pushes = 0, pops = 0, full_lo = 1, full_hi = 0;
  bit pop_now, done_seen, rd_seen;
  task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
  endtask
  task automatic monitor();
    pop_now = resp_fifo_rd_en;
    rd_seen |= resp_fifo_rd_en;
    if (resp_fifo_rd_en) pops++;
    if (req_fifo_wr_en) begin
      pushes++;
      chk("push_while_full", req_fifo_full, 0);
      if (fq.size() == 0) chk("unexpected_push", 1, 0);
      else begin
        plan_t p;
        chk("req_flit", req_fifo_wdata, fq.pop_front());
        if (pq.size() > 0) begin
          p = pq.pop_front();
          pnd.push_back(pend_t'{cyc_n + p.dly, p.resp});
        end
      end
    end
    if (pready) begin
      if (dq.size() == 0) chk("unexpected_pready", 1, 0);
      else begin
        done_t e;
        e = dq.pop_front();
        chk("prdata", prdata, e.xd);
        chk("pslverr", pslverr, e.xe);
        chk("latency", cyc_n - e.t0, e.lat);
        done_seen = 1;
      end
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc_n++;
    #1;
    if (pop_now) begin
      if (rq.size() == 0) chk("pop_empty", 1, 0);
      else resp_fifo_rdata = rq.pop_front();
    end
    while (pnd.size() > 0 && pnd[0].at <= cyc_n) begin
      rq.push_back(pnd[0].resp);
      void'(pnd.pop_front());
    end
    resp_fifo_empty = rq.size() == 0;
    req_fifo_full = cyc_n >= full_lo && cyc_n <= full_hi;
  endtask
  task automatic xfer(vec_t v);
    psel = 1; penable = 0; pwrite = v.w; paddr = v.a; pwdata = v.d;
    full_lo = cyc_n + 1;
    full_hi = cyc_n + v.f;
    fq.push_back({v.w, v.a, v.d});
    pq.push_back(plan_t'{v.dly, v.resp});
    dq.push_back(done_t'{v.xd, v.xe, v.lat, cyc_n});
    done_seen = 0;
    cyc();
    penable = 1;
    for (int n = 0; n < 40 && !done_seen; n++) cyc();
    if (!done_seen) chk("xfer_no_pready", 0, 1);
    psel = 0; penable = 0;
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_pready"}, pready, 0);
    chk({tag, "_prdata"}, prdata, 0);
    chk({tag, "_pslverr"}, pslverr, 0);
    chk({tag, "_wr_en"}, req_fifo_wr_en, 0);
    chk({tag, "_rd_en"}, resp_fifo_rd_en, 0);
    chk({tag, "_wdata"}, req_fifo_wdata, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    //          w  addr         wdata        f  dly resp                       exp_prdata  err lat
    tbl[0] = '{0, 32'h10, 32'h0,        0, 1, {1'b0, 32'hDEADBEEF}, 32'hDEADBEEF, 0, 4};
    tbl[1] = '{1, 32'h20, 32'hA5A5A5A5, 5, 1, {1'b0, 32'h12345678}, 32'h0,        0, 9};
    tbl[2] = '{0, 32'h30, 32'h0,        0, 1, {1'b1, 32'h0},        32'h0,        1, 4};
    tbl[3] = '{0, 32'h44, 32'h0,        0, 3, {1'b0, 32'hCAFEF00D}, 32'hCAFEF00D, 0, 6};
    tbl[4] = '{1, 32'h48, 32'h5A5A0000, 2, 2, {1'b1, 32'h0000FFFF}, 32'h0,        1, 7};
    tbl[5] = '{0, 32'h4C, 32'h0,        0, 8, {1'b0, 32'h0BADF00D}, 32'h0BADF00D, 0, 11};
    tbl[6] = '{0, 32'h50, 32'h0,        0, 9, {1'b0, 32'h11111111}, 32'h0,        1, 10};
    tbl[7] = '{0, 32'h54, 32'h0,        0, 1, {1'b0, 32'h22222222}, 32'h22222222, 0, 6};
    tbl[8] = '{0, 32'h58, 32'h0,        0, 1, {1'b0, 32'h33333333}, 32'h33333333, 0, 4};
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 0;
    cyc();
    foreach (tbl[i]) xfer(tbl[i]);
    cyc();
    cyc();
    chk("push_count", pushes, 9);
    chk("pop_count", pops, 9);
    chk("resp_fifo_drained", rq.size() + pnd.size(), 0);
    fq.push_back({1'b0, 32'h60, 32'h0});
    pq.push_back(plan_t'{6, {1'b0, 32'h44444444}});
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h60; pwdata = 0;
    cyc();
    penable = 1;
    repeat (3) cyc();
    #2 rst = 1;
    #1 chk_zero("async_reset");
    psel = 0; penable = 0; rd_seen = 0;
    cyc();
    rst = 0;
    repeat (8) cyc();
    chk("rd_en_after_reset", rd_seen, 0);
    chk("resp_left_in_fifo", rq.size(), 1);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
